mbldcm_step_sequencer: RTL



---
 rtl/mbldcm_pkg.sv | 31 +++
 rtl/mbldcm_dead_time.sv | 44 ++++
 rtl/mbldcm_step_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mbldcm_pkg.sv
// Shared constants for the six-step commutation controller: state encoding,
// step count and the per-step commutation table.
package mbldcm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam int         NUM_STEPS = 6;
    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    // One-hot phase masks (bit0=A, bit1=B, bit2=C), entry [s] is step s.
    localparam logic [NUM_STEPS-1:0][2:0] PWM_PHASE =
        {3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
    localparam logic [NUM_STEPS-1:0][2:0] LOW_PHASE =
        {3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010};

    function automatic logic [2:0] pwm_phase(input logic [2:0] step);
        return (step <= LAST_STEP) ? PWM_PHASE[step] : 3'b000;
    endfunction

    function automatic logic [2:0] low_phase(input logic [2:0] step);
        return (step <= LAST_STEP) ? LOW_PHASE[step] : 3'b000;
    endfunction

    function automatic logic [2:0] next_step(input logic [2:0] step, input logic reverse);
        if (reverse) return (step == 3'd0) ? LAST_STEP : step - 3'd1;
        return (step >= LAST_STEP) ? 3'd0 : step + 3'd1;
    endfunction

endpackage

// File: rtl/mbldcm_dead_time.sv
// Dead-time counter shared by all phases: reloads on an explicit load or on any
// PWM edge while running, and reports when the gates may be driven.
module mbldcm_dead_time #(
    parameter int pDeadWidth = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic                  run_i,
    input  logic [pDeadWidth-1:0] dead_time_i,
    input  logic                  high_pwm_i,
    output logic                  clear_o
);

    logic [pDeadWidth-1:0] cnt_q, cnt_d;
    logic                  pwm_q;
    logic                  reload;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        reload = load_i | (run_i & (high_pwm_i != pwm_q));
        cnt_d  = '0;
        if (reload) begin
            cnt_d = dead_time_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - pDeadWidth'(1);
        end
    end

    // Gates are decided from the value the counter takes at this edge.
    assign clear_o = (cnt_d == '0);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= high_pwm_i;
        end
    end

endmodule

// File: rtl/mbldcm_step_sequencer.sv
// Open-loop six-step BLDC commutation: steps the pattern on a programmable
// timer, ramps PWM compare toward a target and drives six gates with dead time.
module mbldcm_step_sequencer
    import mbldcm_pkg::*;
#(
    parameter int pCounterWidth = 32,
    parameter int pPrscSelWidth = 6,
    parameter int pStepWidth    = 32,
    parameter int pDeadWidth    = 8
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iEnable,
    input  logic                     iDirection,
    input  logic [pStepWidth-1:0]    iStepPeriod,
    input  logic [pDeadWidth-1:0]    iDeadTime,
    input  logic [pCounterWidth-1:0] iMaxCnt,
    input  logic [pPrscSelWidth-1:0] iPrscSel,
    input  logic [pCounterWidth-1:0] iTgtCmp,
    input  logic [pCounterWidth-1:0] iRampStep,
    input  logic                     iHighPwm,
    output logic [pCounterWidth-1:0] oMaxCnt,
    output logic [pCounterWidth-1:0] oCmpCnt,
    output logic [pPrscSelWidth-1:0] oPrscSel,
    output logic [2:0]               oGateHigh,
    output logic [2:0]               oGateLow,
    output logic [2:0]               oStep,
    output logic                     oBusy
);

    logic [1:0]               state_q, state_d;
    logic [pStepWidth-1:0]    timer_q, timer_d;
    logic [pStepWidth-1:0]    period_q, period_d;
    logic [pStepWidth-1:0]    period_in;
    logic [2:0]               step_q, step_d;
    logic [pCounterWidth-1:0] cmp_q, cmp_d;
    logic [pCounterWidth-1:0] max_q, max_d;
    logic [pPrscSelWidth-1:0] prsc_q, prsc_d;
    logic [2:0]               gate_high_q, gate_high_d;
    logic [2:0]               gate_low_q, gate_low_d;
    logic                     busy_q;
    logic                     dead_load, dead_clear, gate_on;

    // Move cur toward tgt by at most step without wrapping; a zero step jumps.
    function automatic logic [pCounterWidth-1:0] ramp(
        input logic [pCounterWidth-1:0] cur,
        input logic [pCounterWidth-1:0] tgt,
        input logic [pCounterWidth-1:0] step
    );
        logic [pCounterWidth:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (step == '0) return tgt;
        if (cur < tgt)  return (sum >= {1'b0, tgt}) ? tgt : sum[pCounterWidth-1:0];
        if (cur > tgt)  return (step >= cur - tgt) ? tgt : cur - step;
        return cur;
    endfunction

    assign period_in = (iStepPeriod == '0) ? pStepWidth'(1) : iStepPeriod;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        period_d  = period_q;
        step_d    = step_q;
        cmp_d     = cmp_q;
        max_d     = max_q;
        prsc_d    = prsc_q;
        dead_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmp_d = '0;
                if (iEnable) begin
                    state_d   = ST_RUN;
                    max_d     = iMaxCnt;
                    prsc_d    = iPrscSel;
                    timer_d   = '0;
                    period_d  = period_in;
                    dead_load = 1'b1;
                    cmp_d     = ramp('0, iTgtCmp, iRampStep);
                end
            end
            ST_RUN: begin
                if (!iEnable) begin
                    // Stop takes priority over a coinciding step boundary.
                    state_d   = ST_STOP;
                    cmp_d     = '0;
                    dead_load = 1'b1;
                end else if (timer_q == period_q - pStepWidth'(1)) begin
                    step_d    = next_step(step_q, iDirection);
                    timer_d   = '0;
                    period_d  = period_in;
                    dead_load = 1'b1;
                    cmp_d     = ramp(cmp_q, iTgtCmp, iRampStep);
                end else begin
                    timer_d = timer_q + pStepWidth'(1);
                end
            end
            ST_STOP: begin
                // The dead counter doubles as the stop timer; STOP lasts at least one clock.
                cmp_d = '0;
                if (dead_clear) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        gate_on     = (state_d == ST_RUN) && dead_clear;
        gate_high_d = gate_on ? (pwm_phase(step_d) & {3{iHighPwm}}) : 3'b000;
        gate_low_d  = gate_on ? ((pwm_phase(step_d) & {3{~iHighPwm}}) | low_phase(step_d))
                              : 3'b000;
    end

    mbldcm_dead_time #(.pDeadWidth(pDeadWidth)) u_dead_time (
        .clock_i    (iClock),
        .reset_i    (iReset),
        .load_i     (dead_load),
        .run_i      (state_q == ST_RUN),
        .dead_time_i(iDeadTime),
        .high_pwm_i (iHighPwm),
        .clear_o    (dead_clear)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            period_q    <= pStepWidth'(1);
            step_q      <= 3'd0;
            cmp_q       <= '0;
            max_q       <= '0;
            prsc_q      <= '0;
            gate_high_q <= 3'b000;
            gate_low_q  <= 3'b000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            step_q      <= step_d;
            cmp_q       <= cmp_d;
            max_q       <= max_d;
            prsc_q      <= prsc_d;
            gate_high_q <= gate_high_d;
            gate_low_q  <= gate_low_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign oMaxCnt   = max_q;
    assign oCmpCnt   = cmp_q;
    assign oPrscSel  = prsc_q;
    assign oGateHigh = gate_high_q;
    assign oGateLow  = gate_low_q;
    assign oStep     = step_q;
    assign oBusy     = busy_q;

endmodule
